// File: rtl/roce_role_pkg.sv
// Shared definitions for the tx_meta tracker: FSM state encoding, status-code
// field location and a saturating counter helper.
package roce_role_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  localparam int         STATUS_CODE_LSB = 0;
  localparam int         STATUS_CODE_MSB = 7;
  localparam logic [7:0] STATUS_CODE_OK  = 8'd0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tx_meta_watchdog.sv
// Stall watchdog: counts cycles with metas pending and no status returning,
// and flags expiry once the count reaches TIMEOUT_CYCLES.
module tx_meta_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic pending,
  input  logic stat_fire,
  output logic expired
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active || !pending || stat_fire) begin
      cnt_d = '0;
    end else if (cnt_q != 32'hFFFF_FFFF) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = active && (cnt_q >= TIMEOUT_CYCLES);

endmodule

// File: rtl/tx_meta_tracker.sv
// Tracks tx_meta handshakes against returned status words for one run.
// Optional stall watchdog enabled by defining TX_META_TRACKER_TIMEOUT_EN.
module tx_meta_tracker
  import roce_role_pkg::*;
#(
  parameter int          C_S_AXIS_TX_STATUS_TDATA_WIDTH = 512,
  parameter int          OUTST_W                        = 8,
  parameter int unsigned TIMEOUT_CYCLES                 = 250000000
) (
  input  logic                                      ap_clk,
  input  logic                                      ap_rst_n,
  input  logic                                      start,
  input  logic [31:0]                               expected_metas,
  input  logic [OUTST_W-1:0]                        max_outstanding,
  input  logic                                      meta_tvalid,
  input  logic                                      meta_tready,
  input  logic                                      s_axis_tx_status_tvalid,
  output logic                                      s_axis_tx_status_tready,
  input  logic [C_S_AXIS_TX_STATUS_TDATA_WIDTH-1:0] s_axis_tx_status_tdata,
  output logic                                      throttle,
  output logic                                      busy,
  output logic                                      done,
  output logic [31:0]                               meta_count,
  output logic [31:0]                               ok_count,
  output logic [31:0]                               err_count,
  output logic [31:0]                               elapsed_cycles,
  output logic [OUTST_W-1:0]                        outstanding,
  output logic                                      timeout_flag,
  output tx_state_e                                 dbg_state
);

  // Handshakes: a beat transfers on a cycle where valid and ready are both high.
  tx_state_e          state_q, state_d;
  logic               start_q, tready_q;
  logic [31:0]        exp_q, exp_d, meta_q, meta_d, ok_q, ok_d, err_q, err_d;
  logic [31:0]        elapsed_q, elapsed_d;
  logic [OUTST_W-1:0] out_q, out_d;
  logic               start_rise, meta_fire, stat_fire, run_clear, wd_expired;
  logic [7:0]         code;
  logic               unused_tdata;

  assign start_rise   = start & ~start_q;
  assign meta_fire    = meta_tvalid & meta_tready;
  assign stat_fire    = s_axis_tx_status_tvalid & tready_q;
  assign code         = s_axis_tx_status_tdata[STATUS_CODE_MSB:STATUS_CODE_LSB];
  assign unused_tdata = ^s_axis_tx_status_tdata[C_S_AXIS_TX_STATUS_TDATA_WIDTH-1:STATUS_CODE_MSB+1];
  assign run_clear    = (state_q == ST_IDLE) && start_rise;

`ifdef TX_META_TRACKER_TIMEOUT_EN
  logic timeout_q, timeout_d;

  tx_meta_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .active    (busy),
    .pending   (out_q != '0),
    .stat_fire (stat_fire),
    .expired   (wd_expired)
  );

  always_comb begin
    timeout_d = timeout_q;
    if (run_clear)       timeout_d = 1'b0;
    else if (wd_expired) timeout_d = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) timeout_q <= 1'b0;
    else           timeout_q <= timeout_d;
  end

  assign timeout_flag = timeout_q;
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  assign wd_expired   = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_rise) state_d = (expected_metas == 32'd0) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (meta_q >= exp_q) state_d = ST_DRAIN;
      ST_DRAIN: if (out_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (wd_expired) state_d = ST_DONE;
  end

  always_comb begin
    busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done      = (state_q == ST_DONE);
    throttle  = busy && (out_q >= max_outstanding);
    dbg_state = state_q;
  end

  // Statistics only move while a run is in progress; a stray status with
  // nothing outstanding is an error and cannot drive outstanding negative.
  always_comb begin
    exp_d     = exp_q;
    meta_d    = meta_q;
    ok_d      = ok_q;
    err_d     = err_q;
    elapsed_d = elapsed_q;
    out_d     = out_q;
    if (run_clear) begin
      exp_d     = expected_metas;
      meta_d    = '0;
      ok_d      = '0;
      err_d     = '0;
      elapsed_d = '0;
      out_d     = '0;
    end else if (busy) begin
      elapsed_d = sat_inc32(elapsed_q);
      if (meta_fire && (state_q == ST_RUN)) meta_d = sat_inc32(meta_q);
      if (meta_fire && !stat_fire) begin
        if (out_q != '1) out_d = out_q + {{(OUTST_W-1){1'b0}}, 1'b1};
      end else if (stat_fire && !meta_fire && (out_q != '0)) begin
        out_d = out_q - {{(OUTST_W-1){1'b0}}, 1'b1};
      end
      if (stat_fire) begin
        if (!meta_fire && (out_q == '0)) err_d = sat_inc32(err_q);
        else if (code == STATUS_CODE_OK) ok_d  = sat_inc32(ok_q);
        else                             err_d = sat_inc32(err_q);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      start_q   <= 1'b0;
      tready_q  <= 1'b0;
      exp_q     <= '0;
      meta_q    <= '0;
      ok_q      <= '0;
      err_q     <= '0;
      elapsed_q <= '0;
      out_q     <= '0;
    end else begin
      start_q   <= start;
      tready_q  <= 1'b1;
      exp_q     <= exp_d;
      meta_q    <= meta_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      elapsed_q <= elapsed_d;
      out_q     <= out_d;
    end
  end

  assign s_axis_tx_status_tready = tready_q;
  assign meta_count              = meta_q;
  assign ok_count                = ok_q;
  assign err_count               = err_q;
  assign elapsed_cycles          = elapsed_q;
  assign outstanding             = out_q;

endmodule

// File: doc/tx_meta_tracker.md
TX_META_TRACKER -- requirements
Module: tx_meta_tracker

Interface
REQ-001 SHALL have parameter C_S_AXIS_TX_STATUS_TDATA_WIDTH, default 512, width of the status stream data.
REQ-002 SHALL have parameter OUTST_W, default 8, width of the outstanding-request counter.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250000000, watchdog limit in ap_clk cycles.
REQ-004 SHALL have port ap_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port ap_rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  level; its rising edge begins a run.
REQ-007 SHALL have port expected_metas  in  32  number of meta handshakes in one run; sampled at the start edge.
REQ-008 SHALL have port max_outstanding  in  OUTST_W  throttle threshold.
REQ-009 SHALL have port meta_tvalid  in  1  snooped tx_meta tvalid (observe only).
REQ-010 SHALL have port meta_tready  in  1  snooped tx_meta tready (observe only).
REQ-011 SHALL have port s_axis_tx_status_tvalid  in  1  status stream valid.
REQ-012 SHALL have port s_axis_tx_status_tready  out  1  status stream ready.
REQ-013 SHALL have port s_axis_tx_status_tdata  in  C_S_AXIS_TX_STATUS_TDATA_WIDTH  status word; bits [7:0] hold the code, 0 = success.
REQ-014 SHALL have port throttle  out  1  asks the upstream meta generator to hold off.
REQ-015 SHALL have port busy  out  1  run in progress.
REQ-016 SHALL have port done  out  1  one-cycle end-of-run pulse.
REQ-017 SHALL have ports meta_count, ok_count, err_count, elapsed_cycles  out  32 each  run statistics.
REQ-018 SHALL have port outstanding  out  OUTST_W  metas issued but not yet completed.
REQ-019 SHALL have port timeout_flag  out  1  sticky watchdog indication.

Function
REQ-020 SHALL define meta_fire as meta_tvalid & meta_tready, and stat_fire as s_axis_tx_status_tvalid & s_axis_tx_status_tready.
REQ-021 SHALL drive s_axis_tx_status_tready to 1 in every state except reset.
REQ-022 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-023 SHALL, in IDLE on a start rising edge, clear all counters and timeout_flag, latch expected_metas, and enter RUN on the next cycle.
REQ-024 SHALL, in RUN, count meta_fire in meta_count and enter DRAIN in the cycle after meta_count reaches the latched expected value.
REQ-025 SHALL go IDLE->DRAIN directly when expected_metas = 0.
REQ-026 SHALL, in DRAIN, enter DONE when outstanding = 0.
REQ-027 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE.
REQ-028 SHALL hold all counters in IDLE until the next start edge.
REQ-029 SHALL increment outstanding on meta_fire alone, decrement it on stat_fire alone, and leave it unchanged when both occur in the same cycle.
REQ-030 SHALL, on stat_fire with outstanding = 0 and no simultaneous meta_fire, increment err_count and keep outstanding at 0.
REQ-031 SHALL saturate outstanding at all-ones on meta_fire.
REQ-032 SHALL, on stat_fire, increment ok_count when code = 0 and err_count otherwise.
REQ-033 SHALL saturate all 32-bit counters at 0xFFFFFFFF.
REQ-034 SHALL count elapsed_cycles once per cycle in RUN and DRAIN.
REQ-035 SHALL drive throttle combinationally as busy & (outstanding >= max_outstanding).
REQ-036 SHALL drive throttle to 1 when max_outstanding = 0 while busy.
REQ-037 SHALL assert busy in RUN and DRAIN only.
REQ-038 SHALL ignore meta_fire and stat_fire in IDLE.
REQ-039 SHALL ignore a start edge while busy.

Reset
REQ-040 SHALL, while ap_rst_n = 0, asynchronously force: state IDLE, all counters 0, outstanding 0, timeout_flag 0, done 0, busy 0, throttle 0, s_axis_tx_status_tready 0.
REQ-041 SHALL abandon any run on reset mid-run without producing a done pulse.

Configuration
REQ-042 SHALL, with macro TX_META_TRACKER_TIMEOUT_EN defined, count cycles in RUN/DRAIN with outstanding > 0 and no stat_fire.
REQ-043 SHALL, with TX_META_TRACKER_TIMEOUT_EN defined, clear that watchdog count on any stat_fire or when outstanding = 0.
REQ-044 SHALL, with TX_META_TRACKER_TIMEOUT_EN defined, set timeout_flag and enter DONE when the watchdog count reaches TIMEOUT_CYCLES.
REQ-045 SHALL, without TX_META_TRACKER_TIMEOUT_EN, contain no watchdog logic and tie timeout_flag to 0.

Structure
REQ-046 SHALL place the FSM state enum, the status-code field position [7:0] and the success code 0 in shared package roce_role_pkg.
REQ-047 SHALL implement the watchdog as sub-module tx_meta_watchdog.

Verification
REQ-048 SHALL test: expected=4, 4 metas, then 4 status with code 0 -> meta=4, ok=4, err=0, outstanding=0, one done pulse.
REQ-049 SHALL test: meta_fire and stat_fire in the same cycle with outstanding=2 -> outstanding stays 2.
REQ-050 SHALL test: max_outstanding=2, 2 metas with no status -> throttle=1; one status -> throttle=0.
REQ-051 SHALL test: status code 0x05 -> err_count+1; status with outstanding=0 -> err_count+1, outstanding stays 0.
REQ-052 SHALL test: with TX_META_TRACKER_TIMEOUT_EN and TIMEOUT_CYCLES=100, 1 meta and no status -> timeout_flag=1 and done after 100 cycles.
REQ-053 SHALL test: ap_rst_n low in DRAIN -> all outputs 0 immediately, no done pulse.
